mem_access_stage: RTL and testbench

Pipeline MEM stage, directly downstream of the EX/MEM register and upstream of writeback. It consumes the EX/MEM control and data outputs and performs loads and stores on a variable-latency req/ack data-memory port. It handles byte/half/word lane steering and load sign extension, and stalls upstream stages while an access is outstanding. It contains the MEM/WB output register.

---
 rtl/mem_pkg.sv | 17 +
 rtl/load_store_align.sv | 75 +++++++
 rtl/mem_access_stage.sv | 208 ++++++++++++++++++++
 tb/tb_mem_access_stage.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the MEM stage: funct3 access encodings and the
// access FSM state type.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/load_store_align.sv
// Combinational byte-lane steering for the MEM stage.
//   funct3_i      access size/sign
//   addr_lo_i     effective address bits [1:0]
//   mem_read_i    load access
//   mem_write_i   store access
//   store_data_i  raw store data (low bits significant)
//   rdata_i       word returned by data memory
//   be_o          byte enables for the access size/offset
//   wdata_o       store data replicated across lanes
//   load_data_o   selected and sign/zero-extended load data
//   bad_o         illegal encoding or misaligned address
module load_store_align
  import mem_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic [31:0] store_data_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] load_data_o,
  output logic        bad_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        misalign;
  logic        illegal;

  always_comb begin
    byte_sel    = rdata_i[{addr_lo_i, 3'b000} +: 8];
    half_sel    = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    be_o        = '0;
    wdata_o     = store_data_i;
    load_data_o = '0;
    misalign    = 1'b0;

    // funct3[1:0] gives the access size for both signed and unsigned loads
    case (funct3_i[1:0])
      2'b00: begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {4{store_data_i[7:0]}};
      end
      2'b01: begin
        be_o     = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_o  = {2{store_data_i[15:0]}};
        misalign = addr_lo_i[0];
      end
      2'b10: begin
        be_o     = '1;
        misalign = |addr_lo_i;
      end
      default: be_o = '0;
    endcase

    case (funct3_i)
      F3_B:    load_data_o = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    load_data_o = {{16{half_sel[15]}}, half_sel};
      F3_W:    load_data_o = rdata_i;
      F3_BU:   load_data_o = {24'd0, byte_sel};
      F3_HU:   load_data_o = {16'd0, half_sel};
      default: load_data_o = '0;
    endcase

    illegal = (mem_read_i & mem_write_i)
            | (mem_read_i & ((funct3_i == 3'b011) | (funct3_i == 3'b110) |
                             (funct3_i == 3'b111)))
            | (mem_write_i & ~((funct3_i == F3_B) | (funct3_i == F3_H) |
                               (funct3_i == F3_W)));
    bad_o = illegal | misalign;
  end

endmodule

// File: rtl/mem_access_stage.sv
// Pipeline MEM stage: issues loads/stores on a req/ack data-memory port,
// stalls upstream while an access is outstanding and holds the MEM/WB
// register.
//   clk, rst                       clock, async active-high reset
//   RegWrite_in..funct3_in         EX/MEM control and data
//   dmem_req/we/addr/wdata/be      registered memory request
//   dmem_ack, dmem_rdata           memory completion and read data
//   mem_stall                      hold EX/MEM and upstream (combinational)
//   misalign_fault, timeout_fault  one-cycle fault pulses
//   RegWrite_out..rd_out           MEM/WB register outputs
module mem_access_stage
  import mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWrite_in,
  input  logic        MemtoReg_in,
  input  logic        MemRead_in,
  input  logic        MemWrite_in,
  input  logic [31:0] alu_result_in,
  input  logic [31:0] reg_data2_in,
  input  logic [4:0]  rd_in,
  input  logic [2:0]  funct3_in,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        mem_stall,
  output logic        misalign_fault,
  output logic        timeout_fault,
  output logic        RegWrite_out,
  output logic        MemtoReg_out,
  output logic [31:0] mem_data_out,
  output logic [31:0] alu_result_out,
  output logic [4:0]  rd_out
);

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] ld_data_q, ld_data_d;
  logic        misalign_q, misalign_d;
  logic        timeout_q, timeout_d;
  logic        rw_q, rw_d;
  logic        mtr_q, mtr_d;
  logic [31:0] data_q, data_d;
  logic [31:0] alu_q, alu_d;
  logic [4:0]  rd_q, rd_d;
  logic        stall_c;

  logic        access;
  logic        lsa_bad;
  logic [3:0]  lsa_be;
  logic [31:0] lsa_wdata;
  logic [31:0] lsa_load;

  assign access = MemRead_in | MemWrite_in;

  load_store_align u_align (
    .funct3_i     (funct3_in),
    .addr_lo_i    (alu_result_in[1:0]),
    .mem_read_i   (MemRead_in),
    .mem_write_i  (MemWrite_in),
    .store_data_i (reg_data2_in),
    .rdata_i      (dmem_rdata),
    .be_o         (lsa_be),
    .wdata_o      (lsa_wdata),
    .load_data_o  (lsa_load),
    .bad_o        (lsa_bad)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    ld_data_d  = ld_data_q;
    misalign_d = 1'b0;
    timeout_d  = 1'b0;
    rw_d       = rw_q;
    mtr_d      = mtr_q;
    data_d     = data_q;
    alu_d      = alu_q;
    rd_d       = rd_q;
    stall_c    = 1'b0;

    case (state_q)
      IDLE: begin
        rw_d   = RegWrite_in;
        mtr_d  = MemtoReg_in;
        alu_d  = alu_result_in;
        rd_d   = rd_in;
        data_d = '0;
        if (access) begin
          if (lsa_bad) begin
            rw_d       = 1'b0;
            misalign_d = 1'b1;
          end else begin
            stall_c = 1'b1;
            req_d   = 1'b1;
            we_d    = MemWrite_in;
            addr_d  = {alu_result_in[31:2], 2'b00};
            wdata_d = lsa_wdata;
            be_d    = lsa_be;
            cnt_d   = '0;
            state_d = WAIT;
            // WB sees a bubble until the access retires in RESP
            rw_d    = 1'b0;
            mtr_d   = 1'b0;
            alu_d   = '0;
            rd_d    = '0;
          end
        end
      end
      WAIT: begin
        stall_c = 1'b1;
        cnt_d   = cnt_q + 8'd1;
        if (dmem_ack) begin
          req_d     = 1'b0;
          ld_data_d = lsa_load;
          state_d   = RESP;
        end else if (cnt_q == TO_LAST) begin
          req_d     = 1'b0;
          ld_data_d = '0;
          timeout_d = 1'b1;
          state_d   = RESP;
        end
      end
      RESP: begin
        // EX/MEM is still holding the instruction that made the access
        rw_d    = RegWrite_in & ~timeout_q;
        mtr_d   = MemtoReg_in;
        alu_d   = alu_result_in;
        rd_d    = rd_in;
        data_d  = MemRead_in ? ld_data_q : '0;
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      ld_data_q  <= '0;
      misalign_q <= 1'b0;
      timeout_q  <= 1'b0;
      rw_q       <= 1'b0;
      mtr_q      <= 1'b0;
      data_q     <= '0;
      alu_q      <= '0;
      rd_q       <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      ld_data_q  <= ld_data_d;
      misalign_q <= misalign_d;
      timeout_q  <= timeout_d;
      rw_q       <= rw_d;
      mtr_q      <= mtr_d;
      data_q     <= data_d;
      alu_q      <= alu_d;
      rd_q       <= rd_d;
    end
  end

  // stall is combinational, so mask it while reset holds the stage idle
  assign mem_stall      = stall_c & ~rst;
  assign dmem_req       = req_q;
  assign dmem_we        = we_q;
  assign dmem_addr      = addr_q;
  assign dmem_wdata     = wdata_q;
  assign dmem_be        = be_q;
  assign misalign_fault = misalign_q;
  assign timeout_fault  = timeout_q;
  assign RegWrite_out   = rw_q;
  assign MemtoReg_out   = mtr_q;
  assign mem_data_out   = data_q;
  assign alu_result_out = alu_q;
  assign rd_out         = rd_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage with a scoreboard of expected
// MEM/WB results and a latency-programmable memory responder.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWrite_in, MemtoReg_in, MemRead_in, MemWrite_in;
  logic [31:0] alu_result_in, reg_data2_in;
  logic [4:0]  rd_in;
  logic [2:0]  funct3_in;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        mem_stall, misalign_fault, timeout_fault;
  logic        RegWrite_out, MemtoReg_out;
  logic [31:0] mem_data_out, alu_result_out;
  logic [4:0]  rd_out;

  always #5 clk = ~clk;

  mem_access_stage #(.TIMEOUT_CYC(4)) dut (
    .clk(clk), .rst(rst),
    .RegWrite_in(RegWrite_in), .MemtoReg_in(MemtoReg_in),
    .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in),
    .alu_result_in(alu_result_in), .reg_data2_in(reg_data2_in),
    .rd_in(rd_in), .funct3_in(funct3_in),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .mem_stall(mem_stall), .misalign_fault(misalign_fault),
    .timeout_fault(timeout_fault),
    .RegWrite_out(RegWrite_out), .MemtoReg_out(MemtoReg_out),
    .mem_data_out(mem_data_out), .alu_result_out(alu_result_out),
    .rd_out(rd_out)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic        rw;
    logic        mtr;
    logic [31:0] data;
    logic [31:0] alu;
    logic [4:0]  rd;
  } wb_t;
  wb_t sb_q[$];

  // memory responder: ack in WAIT cycle number ack_lat (0 = first), -1 never
  int          ack_lat   = -1;
  logic [31:0] rdata_cfg = '0;
  logic        late_ack  = 1'b0;
  initial begin
    int wcnt;
    wcnt = 0;
    dmem_ack = 1'b0;
    dmem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      dmem_ack = 1'b0;
      if (late_ack) begin
        dmem_ack = 1'b1;
        late_ack = 1'b0;
      end else if (dmem_req) begin
        if (wcnt == ack_lat) begin
          dmem_ack   = 1'b1;
          dmem_rdata = rdata_cfg;
        end
        wcnt++;
      end else begin
        wcnt = 0;
      end
    end
  end

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [1:0] a);
    case (f3)
      3'b000, 3'b100: return 4'b0001 << a;
      3'b001, 3'b101: return a[1] ? 4'b1100 : 4'b0011;
      default:        return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
    case (f3)
      3'b000:  return {d[7:0], d[7:0], d[7:0], d[7:0]};
      3'b001:  return {d[15:0], d[15:0]};
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [1:0] a,
                                         input logic [31:0] r);
    logic [31:0] b, h;
    b = r >> (8 * a);
    h = r >> (16 * a[1]);
    case (f3)
      3'b000:  return {{24{b[7]}}, b[7:0]};
      3'b100:  return {24'd0, b[7:0]};
      3'b001:  return {{16{h[15]}}, h[15:0]};
      3'b101:  return {16'd0, h[15:0]};
      default: return r;
    endcase
  endfunction

  // Presents one instruction right after a negedge, follows it through any
  // stall, then compares the MEM/WB register after the consuming edge.
  task automatic issue(input string tag, input logic rd_en, input logic wr_en,
                       input logic rw, input logic mtr, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [4:0] rdn, input int lat, input logic [31:0] rdat,
                       input int exp_stall, input int exp_req,
                       input logic exp_mis, input logic exp_to);
    int stalls, reqs;
    logic to_seen, done, cap_we;
    logic [31:0] cap_addr, cap_wd;
    logic [3:0] cap_be;
    wb_t e, o;
    MemRead_in = rd_en; MemWrite_in = wr_en; RegWrite_in = rw; MemtoReg_in = mtr;
    funct3_in = f3; alu_result_in = addr; reg_data2_in = wd; rd_in = rdn;
    ack_lat = lat; rdata_cfg = rdat;
    e.rw   = rw & ~exp_mis & ~exp_to;
    e.mtr  = mtr;
    e.alu  = addr;
    e.rd   = rdn;
    e.data = (rd_en & ~exp_mis & ~exp_to) ? m_load(f3, addr[1:0], rdat) : 32'd0;
    sb_q.push_back(e);
    stalls = 0; reqs = 0; to_seen = 1'b0; done = 1'b0;
    cap_we = 1'b0; cap_addr = '0; cap_wd = '0; cap_be = '0;
    for (int i = 0; i < 64; i++) begin
      #1;
      if (dmem_req) begin
        reqs++;
        cap_we = dmem_we; cap_addr = dmem_addr; cap_wd = dmem_wdata; cap_be = dmem_be;
      end
      if (timeout_fault) to_seen = 1'b1;
      if (!mem_stall) begin
        done = 1'b1;
        break;
      end
      stalls++;
      @(negedge clk);
    end
    check_eq({tag, ".done"}, 32'(done), 32'd1);
    check_eq({tag, ".stall"}, 32'(stalls), 32'(exp_stall));
    check_eq({tag, ".req"}, 32'(reqs), 32'(exp_req));
    check_eq({tag, ".tmo"}, 32'(to_seen), 32'(exp_to));
    if (exp_req > 0) begin
      check_eq({tag, ".addr"}, cap_addr, {addr[31:2], 2'b00});
      check_eq({tag, ".we"}, 32'(cap_we), 32'(wr_en));
      check_eq({tag, ".be"}, 32'(cap_be), 32'(m_be(f3, addr[1:0])));
      if (wr_en) check_eq({tag, ".wdata"}, cap_wd, m_wdata(f3, wd));
    end
    @(negedge clk);
    check_eq({tag, ".mis"}, 32'(misalign_fault), 32'(exp_mis));
    o = sb_q.pop_front();
    check_eq({tag, ".rw"}, 32'(RegWrite_out), 32'(o.rw));
    check_eq({tag, ".mtr"}, 32'(MemtoReg_out), 32'(o.mtr));
    check_eq({tag, ".data"}, mem_data_out, o.data);
    check_eq({tag, ".alu"}, alu_result_out, o.alu);
    check_eq({tag, ".rd"}, 32'(rd_out), 32'(o.rd));
  endtask

  task automatic nop_inputs();
    MemRead_in = 1'b0; MemWrite_in = 1'b0; RegWrite_in = 1'b0; MemtoReg_in = 1'b0;
    funct3_in = '0; alu_result_in = '0; reg_data2_in = '0; rd_in = '0;
  endtask

  initial begin
    rst = 1'b1;
    nop_inputs();
    @(negedge clk);
    @(negedge clk);
    check_eq("rst.req", 32'(dmem_req), 32'd0);
    check_eq("rst.stall", 32'(mem_stall), 32'd0);
    check_eq("rst.rw", 32'(RegWrite_out), 32'd0);
    check_eq("rst.data", mem_data_out, 32'd0);
    check_eq("rst.alu", alu_result_out, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    //     tag    rd wr rw mtr f3      addr          wdata          rd  lat rdata          st rq mis to
    issue("sw",   0, 1, 0, 0, 3'b010, 32'h100, 32'hDEADBEEF, 5'd0,  0, 32'h0,          2, 1, 0, 0);
    issue("lb",   1, 0, 1, 1, 3'b000, 32'h203, 32'h0,        5'd5,  3, 32'h80FF_1234, 5, 4, 0, 0);
    issue("lbu",  1, 0, 1, 1, 3'b100, 32'h203, 32'h0,        5'd6,  3, 32'h80FF_1234, 5, 4, 0, 0);
    issue("sh",   0, 1, 0, 0, 3'b001, 32'h102, 32'h0000ABCD, 5'd0,  0, 32'h0,          2, 1, 0, 0);
    issue("lhmis",1, 0, 1, 1, 3'b001, 32'h101, 32'h0,        5'd8,  0, 32'h0,          0, 0, 1, 0);
    issue("alu",  0, 0, 1, 0, 3'b000, 32'h55,  32'h0,        5'd7,  0, 32'h0,          0, 0, 0, 0);
    issue("lh",   1, 0, 1, 1, 3'b001, 32'h202, 32'h0,        5'd9,  1, 32'h80FF_1234, 3, 2, 0, 0);
    issue("lhu",  1, 0, 1, 1, 3'b101, 32'h200, 32'h0,        5'd10, 0, 32'h80FF_9234, 2, 1, 0, 0);
    issue("sb",   0, 1, 0, 0, 3'b000, 32'h101, 32'h1234565A, 5'd0,  2, 32'h0,          4, 3, 0, 0);
    issue("ill",  1, 0, 1, 1, 3'b011, 32'h300, 32'h0,        5'd11, 0, 32'h0,          0, 0, 1, 0);
    issue("swmis",0, 1, 0, 0, 3'b010, 32'h302, 32'h1,        5'd0,  0, 32'h0,          0, 0, 1, 0);
    issue("tmo",  1, 0, 1, 1, 3'b010, 32'h300, 32'h0,        5'd12,-1, 32'h0,          5, 4, 0, 1);
    late_ack = 1'b1;
    issue("late0",0, 0, 1, 0, 3'b000, 32'h77,  32'h0,        5'd13, 0, 32'h0,          0, 0, 0, 0);
    issue("late1",0, 0, 1, 0, 3'b000, 32'h78,  32'h0,        5'd14, 0, 32'h0,          0, 0, 0, 0);

    // reset in the middle of an outstanding load
    MemRead_in = 1'b1; MemWrite_in = 1'b0; RegWrite_in = 1'b1; MemtoReg_in = 1'b1;
    funct3_in = 3'b010; alu_result_in = 32'h400; reg_data2_in = '0; rd_in = 5'd9;
    ack_lat = -1;
    @(negedge clk);
    #1;
    check_eq("mid.req", 32'(dmem_req), 32'd1);
    rst = 1'b1;
    #1;
    check_eq("mid.rreq", 32'(dmem_req), 32'd0);
    check_eq("mid.stall", 32'(mem_stall), 32'd0);
    check_eq("mid.tmo", 32'(timeout_fault), 32'd0);
    check_eq("mid.rw", 32'(RegWrite_out), 32'd0);
    nop_inputs();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    issue("lwpost",1, 0, 1, 1, 3'b010, 32'h400, 32'h0,       5'd9,  1, 32'h1234_5678, 3, 2, 0, 0);
    nop_inputs();
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end

endmodule
